// File: rtl/peristaltic_pump_sequencer_if.sv
// rtl/peristaltic_pump_sequencer_if.sv - command handshake bundle for the pump sequencer
interface peristaltic_pump_sequencer_if #(
    parameter int DWELL_W = 16,
    parameter int COUNT_W = 16
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [DWELL_W-1:0] cmd_dwell;
    logic [COUNT_W-1:0] cmd_cycles;

    modport master (
        output cmd_valid, cmd_dir, cmd_dwell, cmd_cycles,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_dwell, cmd_cycles,
        output cmd_ready
    );
endinterface

// File: rtl/peristaltic_pump_sequencer.sv
// rtl/peristaltic_pump_sequencer.sv - N-valve peristaltic pump actuation sequencer
module peristaltic_pump_sequencer #(
    parameter int NUM_VALVES    = 3,
    parameter int DWELL_W       = 16,
    parameter int COUNT_W       = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    peristaltic_pump_sequencer_if.slave cmd,
    input  logic                      abort,
    output logic [NUM_VALVES-1:0]     valve_ctrl,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic [COUNT_W-1:0]        cycles_done
);
    localparam int NUM_PHASES = 2 * NUM_VALVES;
    localparam int PW         = $clog2(NUM_PHASES);
    localparam int SW         = $clog2(SETTLE_CYCLES + 1);
    localparam logic [PW-1:0] LAST_PHASE  = PW'(NUM_PHASES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;

    state_t               state, state_n;
    logic [PW-1:0]        phase, phase_n, phase_adv;
    logic [DWELL_W-1:0]   dwell_cnt, dwell_cnt_n;
    logic [DWELL_W-1:0]   dwell_last, dwell_last_n;
    logic                 dir, dir_n;
    logic [COUNT_W-1:0]   cycles, cycles_n;
    logic [COUNT_W-1:0]   cycles_done_n, cycles_inc;
    logic [SW-1:0]        settle_cnt, settle_cnt_n;
    logic                 abort_pend, abort_pend_n, abort_hit;
    logic [NUM_VALVES-1:0] valve_ctrl_n;
    logic                 busy_n, done_n, aborted_n;
    logic                 phase_end, cycle_end;

    // Even phases vent one valve; odd phases vent the overlap pair.
    function automatic logic [NUM_VALVES-1:0] pattern(input logic [PW-1:0] p);
        logic [NUM_VALVES-1:0] v;
        int idx;
        int nxt;
        idx = int'(p) / 2;
        nxt = (idx + 1 == NUM_VALVES) ? 0 : idx + 1;
        v   = '1;
        for (int i = 0; i < NUM_VALVES; i++) begin
            if (i == idx || (p[0] && i == nxt)) v[i] = 1'b0;
        end
        return v;
    endfunction

    assign cmd.cmd_ready = (state == IDLE);

    always_comb begin
        state_n       = state;
        phase_n       = phase;
        dwell_cnt_n   = dwell_cnt;
        dwell_last_n  = dwell_last;
        dir_n         = dir;
        cycles_n      = cycles;
        cycles_done_n = cycles_done;
        settle_cnt_n  = settle_cnt;
        abort_pend_n  = abort_pend;
        aborted_n     = aborted;
        valve_ctrl_n  = '1;
        done_n        = 1'b0;

        phase_end  = (dwell_cnt == dwell_last);
        phase_adv  = dir ? ((phase == '0) ? LAST_PHASE : phase - 1'b1)
                         : ((phase == LAST_PHASE) ? '0 : phase + 1'b1);
        cycle_end  = (phase_adv == '0);
        cycles_inc = cycles_done + 1'b1;
        abort_hit  = abort_pend | abort;

        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    state_n       = RUN;
                    dir_n         = cmd.cmd_dir;
                    dwell_last_n  = (cmd.cmd_dwell == '0) ? '0 : cmd.cmd_dwell - 1'b1;
                    cycles_n      = cmd.cmd_cycles;
                    cycles_done_n = '0;
                    aborted_n     = 1'b0;
                    abort_pend_n  = 1'b0;
                    phase_n       = '0;
                    dwell_cnt_n   = '0;
                    valve_ctrl_n  = pattern('0);
                end
            end
            RUN: begin
                valve_ctrl_n = pattern(phase);
                abort_pend_n = abort_hit;
                if (phase_end) begin
                    dwell_cnt_n = '0;
                    // A cycle counts only when its final phase finishes, even if abort lands there.
                    if (cycle_end) cycles_done_n = cycles_inc;
                    if (abort_hit || (cycle_end && cycles != '0 && cycles_inc == cycles)) begin
                        state_n      = SETTLE;
                        settle_cnt_n = '0;
                        aborted_n    = abort_hit;
                        abort_pend_n = 1'b0;
                        valve_ctrl_n = '1;
                    end else begin
                        phase_n      = phase_adv;
                        valve_ctrl_n = pattern(phase_adv);
                    end
                end else begin
                    dwell_cnt_n = dwell_cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    settle_cnt_n = settle_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= '0;
            dwell_cnt   <= '0;
            dwell_last  <= '0;
            dir         <= 1'b0;
            cycles      <= '0;
            cycles_done <= '0;
            settle_cnt  <= '0;
            abort_pend  <= 1'b0;
            aborted     <= 1'b0;
            valve_ctrl  <= '1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            dwell_cnt   <= dwell_cnt_n;
            dwell_last  <= dwell_last_n;
            dir         <= dir_n;
            cycles      <= cycles_n;
            cycles_done <= cycles_done_n;
            settle_cnt  <= settle_cnt_n;
            abort_pend  <= abort_pend_n;
            aborted     <= aborted_n;
            valve_ctrl  <= valve_ctrl_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end
endmodule
